// File: rtl/ahb_burst_master_seq_pkg.sv
// rtl/ahb_burst_master_seq_pkg.sv - AHB transfer, burst and response encodings
package ahb_burst_master_seq_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } ahb_trans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE              = 3'd0,
        BURST_UNDEFINED_INCREMENT = 3'd1,
        BURST_WRAP_4              = 3'd2,
        BURST_INCR_4              = 3'd3,
        BURST_WRAP_8              = 3'd4,
        BURST_INCR_8              = 3'd5,
        BURST_WRAP_16             = 3'd6,
        BURST_INCR_16             = 3'd7
    } ahb_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } ahb_resp_t;

endpackage

// File: rtl/ahb_burst_master_seq.sv
// rtl/ahb_burst_master_seq.sv - AHB burst master address sequencer with BUSY, ERROR and RETRY/SPLIT handling
module ahb_burst_master_seq
    import ahb_burst_master_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  ahb_burst_t            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_stall,
    output logic [ADDR_WIDTH-1:0] haddr,
    output ahb_trans_t            htrans,
    output ahb_burst_t            hburst,
    output logic [2:0]            hsize,
    input  logic                  hready,
    input  ahb_resp_t             hresp,
    output logic                  beat_done,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam int CW = LEN_WIDTH + 1;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    ahb_trans_t            htrans_q, htrans_d;
    ahb_burst_t            hburst_q, hburst_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [CW-1:0]         rem_q, rem_d;         // address phases still to be accepted
    logic [ADDR_WIDTH-1:0] mask_q, mask_d;       // wrap window mask, all ones for incrementing bursts
    logic                  dp_q, dp_d;           // a real beat is in its data phase
    logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d; // address of that beat, re-issued on RETRY/SPLIT
    logic                  rej_q, rej_d;
    logic                  resp_err_q, resp_err_d;

    // Command decode
    logic [4:0]            fix_beats;
    logic                  is_wrap, is_fix_incr, cmd_bad;
    logic [CW-1:0]         cmd_beats;
    logic [ADDR_WIDTH-1:0] cmd_incr, cmd_mask;
    logic [12:0]           end_off;

    always_comb begin
        fix_beats   = 5'd0;
        is_wrap     = 1'b0;
        is_fix_incr = 1'b0;
        case (cmd_burst)
            BURST_WRAP_4:  begin fix_beats = 5'd4;  is_wrap = 1'b1;     end
            BURST_INCR_4:  begin fix_beats = 5'd4;  is_fix_incr = 1'b1; end
            BURST_WRAP_8:  begin fix_beats = 5'd8;  is_wrap = 1'b1;     end
            BURST_INCR_8:  begin fix_beats = 5'd8;  is_fix_incr = 1'b1; end
            BURST_WRAP_16: begin fix_beats = 5'd16; is_wrap = 1'b1;     end
            BURST_INCR_16: begin fix_beats = 5'd16; is_fix_incr = 1'b1; end
            default:       fix_beats = 5'd0;
        endcase
    end

    assign cmd_beats = (cmd_burst == BURST_UNDEFINED_INCREMENT) ?
                           ((cmd_len == '0) ? ONE : {1'b0, cmd_len}) :
                       (cmd_burst == BURST_SINGLE) ? ONE :
                           {{(CW-5){1'b0}}, fix_beats};
    assign cmd_incr = A_ONE << cmd_size;
    assign cmd_mask = is_wrap ? (({{(ADDR_WIDTH-5){1'b0}}, fix_beats} << cmd_size) - A_ONE)
                              : {ADDR_WIDTH{1'b1}};
    // Byte offset one past the last beat, relative to the 1 KB page start
    assign end_off  = {3'b000, cmd_addr[9:0]} + ({8'd0, fix_beats} << cmd_size);
    assign cmd_bad  = (cmd_size > MAX_SIZE) ||
                      ((cmd_addr & (cmd_incr - A_ONE)) != '0) ||
                      (is_fix_incr && (end_off > 13'd1024));

    // Burst address stepping and transfer type for the following beat
    logic [ADDR_WIDTH-1:0] incr, next_addr;
    ahb_trans_t            next_seq, cur_seq;
    logic                  dp_ok, dp_bad;

    assign incr      = A_ONE << hsize_q;
    assign next_addr = (haddr_q & ~mask_q) | ((haddr_q + incr) & mask_q);
    assign next_seq  = ((hburst_q == BURST_UNDEFINED_INCREMENT) && (next_addr[9:0] == 10'd0))
                       ? TRANS_NONSEQ : TRANS_SEQ;
    assign cur_seq   = ((hburst_q == BURST_UNDEFINED_INCREMENT) && (haddr_q[9:0] == 10'd0))
                       ? TRANS_NONSEQ : TRANS_SEQ;
    assign dp_ok     = dp_q && hready && (hresp == RESP_OKAY);
    assign dp_bad    = dp_q && !hready && (hresp != RESP_OKAY);

    // Next-state logic for the burst sequencer
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hburst_d   = hburst_q;
        hsize_d    = hsize_q;
        rem_d      = rem_q;
        mask_d     = mask_q;
        dp_d       = dp_q;
        dp_addr_d  = dp_addr_q;
        rej_d      = 1'b0;
        resp_err_d = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        haddr_d  = cmd_addr;
                        htrans_d = TRANS_NONSEQ;
                        hburst_d = cmd_burst;
                        hsize_d  = cmd_size;
                        rem_d    = cmd_beats;
                        mask_d   = cmd_mask;
                        dp_d     = 1'b0;
                    end
                end
            end
            ST_ADDR, ST_LAST: begin
                if (dp_bad) begin
                    state_d    = ST_RESP;
                    htrans_d   = TRANS_IDLE;
                    dp_d       = 1'b0;
                    resp_err_d = (hresp == RESP_ERROR);
                end else if (hready) begin
                    if (state_q == ST_LAST) begin
                        dp_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else if (htrans_q == TRANS_BUSY) begin
                        // BUSY consumes no beat; its data phase is not a beat either
                        dp_d = 1'b0;
                        if (cmd_stall) htrans_d = TRANS_BUSY;
                        else           htrans_d = cur_seq;
                    end else begin
                        dp_d      = 1'b1;
                        dp_addr_d = haddr_q;
                        rem_d     = rem_q - ONE;
                        if (rem_q == ONE) begin
                            state_d  = ST_LAST;
                            htrans_d = TRANS_IDLE;
                        end else begin
                            haddr_d = next_addr;
                            if (cmd_stall) htrans_d = TRANS_BUSY;
                            else           htrans_d = next_seq;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (hready) begin
                    if (resp_err_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Re-issue the refused beat; it goes back into the remaining count
                        state_d  = ST_ADDR;
                        haddr_d  = dp_addr_q;
                        htrans_d = TRANS_NONSEQ;
                        rem_d    = rem_q + ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bus registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            htrans_q   <= TRANS_IDLE;
            hburst_q   <= BURST_SINGLE;
            hsize_q    <= 3'd0;
            rem_q      <= '0;
            mask_q     <= '0;
            dp_q       <= 1'b0;
            dp_addr_q  <= '0;
            rej_q      <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hburst_q   <= hburst_d;
            hsize_q    <= hsize_d;
            rem_q      <= rem_d;
            mask_q     <= mask_d;
            dp_q       <= dp_d;
            dp_addr_q  <= dp_addr_d;
            rej_q      <= rej_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hburst    = hburst_q;
    assign hsize     = hsize_q;
    assign beat_done = dp_ok;
    assign done      = (state_q == ST_LAST) && dp_ok;
    assign err       = rej_q || ((state_q == ST_RESP) && hready && resp_err_q);

endmodule

// File: doc/ahb_burst_master_seq.md
AHB_BURST_MASTER_SEQ -- requirements
Module: ahb_burst_master_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8..1024, power of two); sets maximum legal size.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, beat-count width for BURST_UNDEFINED_INCREMENT.
REQ-004 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have ports cmd_addr (ADDR_WIDTH), cmd_burst (ahb_burst_t), cmd_size (3) and cmd_len (LEN_WIDTH), all inputs giving start address, burst type, log2 bytes per beat and undefined-increment beat count (0 treated as 1).
REQ-009 SHALL have port cmd_stall  in  1  data source not ready; request BUSY insertion.
REQ-010 SHALL have ports haddr (ADDR_WIDTH), htrans (ahb_trans_t), hburst (ahb_burst_t) and hsize (3), all registered outputs.
REQ-011 SHALL have ports hready (1) and hresp (ahb_resp_t), both inputs.
REQ-012 SHALL have ports beat_done, done and err, each an output 1-bit single-cycle pulse.

Function
REQ-013 SHALL implement states IDLE, ADDR (issuing address phases), LAST (final address accepted, awaiting final data phase) and RESP (second cycle of a two-cycle response).
REQ-014 SHALL assert cmd_ready only in IDLE and SHALL accept a command in IDLE when cmd_valid is high.
REQ-015 SHALL reject a command when cmd_size > log2(DATA_WIDTH/8), when cmd_addr is misaligned to 1<<cmd_size, or when a fixed-length INCR burst would cross a 1 KB boundary; rejection = err pulse the next cycle, stay IDLE, htrans remains IDLE.
REQ-016 SHALL set beat count: SINGLE 1, WRAP_4/INCR_4 4, WRAP_8/INCR_8 8, WRAP_16/INCR_16 16, UNDEFINED_INCREMENT max(cmd_len,1).
REQ-017 SHALL present the first address phase in the cycle after acceptance with htrans NONSEQ, hburst = cmd_burst and hsize = cmd_size.
REQ-018 SHALL advance the address phase only on a cycle where hready is high; haddr, htrans, hburst and hsize SHALL hold while hready is low.
REQ-019 For INCR bursts, SHALL compute next address = addr + (1<<size) modulo 2^ADDR_WIDTH.
REQ-020 For WRAP bursts, with B = beats*(1<<size), SHALL compute next address = (addr & ~(B-1)) | ((addr + (1<<size)) & (B-1)).
REQ-021 SHALL drive htrans SEQ on non-first beats, except that an UNDEFINED_INCREMENT beat landing on a 1 KB boundary SHALL be NONSEQ.
REQ-022 When cmd_stall is high and the next beat is not the first, SHALL drive htrans BUSY with haddr = that next beat's address and not consume a beat; SEQ SHALL resume the cycle after cmd_stall falls.
REQ-023 SHALL pulse beat_done on each cycle where an OKAY data phase completes (hready high).
REQ-024 SHALL pulse done on completion of the final OKAY data phase and return to IDLE with htrans IDLE in the same cycle.
REQ-025 On hresp ERROR with hready low, SHALL enter RESP, drive htrans IDLE the next cycle, abandon remaining beats, pulse err when hready rises, then return to IDLE.
REQ-026 On hresp RETRY or SPLIT with hready low, SHALL enter RESP, drive htrans IDLE, then re-issue the beat in data phase as NONSEQ and continue with the remaining beat count and original hburst.
REQ-027 SHALL keep the remaining-beat counter LEN_WIDTH+1 bits wide, with no wrap on UNDEFINED_INCREMENT lengths.

Reset
REQ-028 While rst is high, SHALL force state IDLE, htrans IDLE, haddr 0, hburst SINGLE, hsize 0, cmd_ready 1, and beat_done/done/err 0, asynchronously and including mid-burst.
REQ-029 SHALL issue no transfer other than IDLE in the first cycle after rst deasserts.

Verification
REQ-030 WRAP_4, size 2, addr 0x38, hready=1 -> haddr 0x38,0x3C,0x30,0x34 with htrans NONSEQ,SEQ,SEQ,SEQ; 4 beat_done pulses; done on the 4th.
REQ-031 UNDEFINED_INCREMENT, len 3, size 2, addr 0x3F8 -> haddr 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ; done after the 3rd beat.
REQ-032 INCR_8, size 2, addr 0x3F0 -> err pulse one cycle after acceptance; htrans stays IDLE throughout.
REQ-033 INCR_4 from 0x100 with hready low 2 cycles at beat 2 and cmd_stall high 1 cycle at beat 3 -> 0x104 held 2 cycles, then BUSY@0x108, then SEQ@0x108.
REQ-034 INCR_4 from 0x200 with ERROR on the beat-2 data phase -> htrans IDLE, err pulse, no done, cmd_ready 1 afterwards.
REQ-035 rst asserted mid-burst of INCR_16 -> htrans IDLE and haddr 0 immediately; a new SINGLE after release starts with NONSEQ.
